reg_scoreboard: RTL and testbench

- Register-write scoreboard and issue controller for the 5-stage LoongArch pipeline; sits beside the decode stage.
- Tracks in-flight GPR writes between issue (ID->EX handoff) and retirement (WB register-file write).
- Replaces per-stage destination-address comparison: decides whether the instruction held in ID may issue or must stall on a read-after-write hazard.
- Also provides a busy bitmap and a stall-cycle performance counter.

---
 rtl/reg_scoreboard.sv | 227 ++++++++++++++++++++++
 tb/tb_reg_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register-write scoreboard and issue controller for the 5-stage LoongArch
// pipeline. It sits beside the decode stage and tracks GPR writes that are
// in flight between issue (ID->EX handoff) and retirement (WB register-file
// write).
//
// Every architectural register except r0 has a small pending-write counter.
// The counter goes up when a writer issues and down when that writer
// retires. The instruction held in ID may issue only if all of these hold:
//   - none of its sources has a pending write,
//   - its destination counter is not saturated,
//   - EX can accept it,
//   - it has not been killed.
//
// Ports:
//   clk         in   1       clock, all state changes on its rising edge
//   reset       in   1       synchronous active-high reset
//   ds_valid    in   1       ID holds a valid instruction
//   ds_re1      in   1       source 1 reads the register file
//   ds_raddr1   in   5       source 1 register number
//   ds_re2      in   1       source 2 reads the register file
//   ds_raddr2   in   5       source 2 register number
//   ds_we       in   1       ID instruction writes a GPR
//   ds_waddr    in   5       ID destination register number
//   ds_kill     in   1       ID instruction cancelled this cycle
//   es_allowin  in   1       EX accepts an instruction this cycle
//   ws_valid    in   1       WB holds a valid instruction
//   ws_we       in   1       WB writes the register file this cycle
//   ws_waddr    in   5       WB destination register number
//   sb_flush    in   1       drop all in-flight tracking
//   ds_issue    out  1       ID instruction moves to EX this cycle
//   ds_stall    out  1       ID instruction is valid but held this cycle
//   sb_busy     out  NREG    bit i set when register i has a pending write
//   stall_cnt   out  PERF_W  saturating count of hazard-stall cycles
//
// Build option:
//   SB_WB_BYPASS_EN
//     When defined, a source whose register is being retired this cycle
//     (counter at 1, WB writing that register now) is not treated as
//     pending. This relies on the register file writing through, so the
//     dependent instruction issues in the retire cycle.
//     When undefined, source checks use the registered counters only, and
//     the dependent instruction issues one cycle after retirement.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic              ds_re1,
  input  logic [4:0]        ds_raddr1,
  input  logic              ds_re2,
  input  logic [4:0]        ds_raddr2,
  input  logic              ds_we,
  input  logic [4:0]        ds_waddr,
  input  logic              ds_kill,
  input  logic              es_allowin,
  input  logic              ws_valid,
  input  logic              ws_we,
  input  logic [4:0]        ws_waddr,
  input  logic              sb_flush,
  output logic              ds_issue,
  output logic              ds_stall,
  output logic [NREG-1:0]   sb_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PerfMax = '1;
  localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [PERF_W-1:0] stallCnt_q;
  logic [PERF_W-1:0] stallCnt_d;

  logic [NREG-1:0] busyVec;
  logic [NREG-1:0] fullVec;
  logic [NREG-1:0] incSel;
  logic [NREG-1:0] decSel;

  logic srcPend1;
  logic srcPend2;
  logic srcHaz1;
  logic srcHaz2;
  logic satHaz;
  logic incActive;
  logic decActive;
  logic retireSameDst;

`ifdef SB_WB_BYPASS_EN
  logic [NREG-1:0] oneVec;
`endif

  // Per-register status flags decoded from the registered counters.
  // Entry 0 is held at zero, so r0 never reports busy or full.
  always_comb begin
    busyVec = '0;
    fullVec = '0;
    for (int i = 1; i < NREG; i++) begin
      busyVec[i] = (cnt_q[i] != '0);
      fullVec[i] = (cnt_q[i] == CntMax);
    end
  end

`ifdef SB_WB_BYPASS_EN
  // Marks registers with exactly one write in flight. If WB retires such a
  // register this cycle, the write-through register file already holds the
  // new value, so a reader of that register does not have to wait.
  always_comb begin
    oneVec = '0;
    for (int i = 1; i < NREG; i++) begin
      oneVec[i] = (cnt_q[i] == CntOne);
    end
  end
`endif

  // The retirement qualifier. A WB write to r0 is discarded by the register
  // file, so it never decrements anything.
  assign decActive = ws_valid & ws_we & (ws_waddr != 5'd0);

  // Pending check for each source. With the bypass enabled, the last
  // outstanding write that is retiring right now no longer blocks readers.
  always_comb begin
    srcPend1 = busyVec[ds_raddr1];
    srcPend2 = busyVec[ds_raddr2];
`ifdef SB_WB_BYPASS_EN
    if (decActive && (ws_waddr == ds_raddr1) && oneVec[ds_raddr1]) begin
      srcPend1 = 1'b0;
    end
    if (decActive && (ws_waddr == ds_raddr2) && oneVec[ds_raddr2]) begin
      srcPend2 = 1'b0;
    end
`endif
  end

  // Hazard detection and the issue decision. This is purely combinational:
  // the decision is made in the same cycle the instruction sits in ID.
  // A saturated destination counter blocks issue, unless WB frees a slot
  // on that same register this cycle.
  assign srcHaz1       = ds_re1 & (ds_raddr1 != 5'd0) & srcPend1;
  assign srcHaz2       = ds_re2 & (ds_raddr2 != 5'd0) & srcPend2;
  assign retireSameDst = decActive & (ws_waddr == ds_waddr);
  assign satHaz        = ds_we & (ds_waddr != 5'd0) & fullVec[ds_waddr] & ~retireSameDst;

  assign ds_issue  = ds_valid & ~ds_kill & es_allowin & ~srcHaz1 & ~srcHaz2 & ~satHaz;
  assign ds_stall  = ds_valid & ~ds_kill & ~ds_issue;
  assign incActive = ds_issue & ds_we & (ds_waddr != 5'd0);

  // One-hot selects for the register being allocated by issue and the
  // register being released by retirement.
  always_comb begin
    incSel = '0;
    decSel = '0;
    if (incActive) begin
      incSel[ds_waddr] = 1'b1;
    end
    if (decActive) begin
      decSel[ws_waddr] = 1'b1;
    end
  end

  // Counter next state.
  //   - A flush clears every counter and ignores that cycle's inc and dec.
  //   - An inc and a dec on the same register cancel each other out.
  //   - A dec on a counter that is already zero is an illegal stimulus.
  //     The counter holds at zero here, and the check below flags it.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sb_flush || (i == 0)) begin
        cnt_d[i] = '0;
      end else if (incSel[i] && !decSel[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (decSel[i] && !incSel[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  // Performance counter. It counts only cycles lost to hazards: cycles
  // where EX was ready but the ID instruction still could not go. It
  // saturates at all-ones, and a pipeline flush does not clear it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (ds_stall && es_allowin && (stallCnt_q != PerfMax)) begin
      stallCnt_d = stallCnt_q + PerfOne;
    end
  end

  // State registers. Reset has priority over flush and over all other
  // updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      stallCnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stallCnt_q <= stallCnt_d;
    end
  end

  // Simulation check: a retirement must always match an earlier issue, so
  // a dec may never reach a counter that is already zero. A flush makes
  // the dec irrelevant, and a same-register inc cancels it, so both are
  // excluded from the check.
  always_ff @(posedge clk) begin
    if (!reset && !sb_flush && decActive && !decSel[0] && !incSel[ws_waddr]) begin
      assert (busyVec[ws_waddr]);
    end
  end

  // The busy map comes straight from registered state, with no bypass.
  assign sb_busy   = busyVec;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed testbench for reg_scoreboard. It drives a linear sequence of
// hand-written pipeline scenarios and compares the outputs against values
// worked out by hand. The scenarios cover:
//   - issue and tracking of a write,
//   - a RAW stall followed by retirement,
//   - r0 handling,
//   - counter saturation,
//   - flush, kill, EX back-pressure and reset.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        ds_valid;
  logic        ds_re1;
  logic [4:0]  ds_raddr1;
  logic        ds_re2;
  logic [4:0]  ds_raddr2;
  logic        ds_we;
  logic [4:0]  ds_waddr;
  logic        ds_kill;
  logic        es_allowin;
  logic        ws_valid;
  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic        sb_flush;
  logic        ds_issue;
  logic        ds_stall;
  logic [31:0] sb_busy;
  logic [31:0] stall_cnt;

  int errors;
  int checks;
  logic [31:0] expStall;

  reg_scoreboard #(
    .NREG   (32),
    .CNT_W  (2),
    .PERF_W (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ds_valid   (ds_valid),
    .ds_re1     (ds_re1),
    .ds_raddr1  (ds_raddr1),
    .ds_re2     (ds_re2),
    .ds_raddr2  (ds_raddr2),
    .ds_we      (ds_we),
    .ds_waddr   (ds_waddr),
    .ds_kill    (ds_kill),
    .es_allowin (es_allowin),
    .ws_valid   (ws_valid),
    .ws_we      (ws_we),
    .ws_waddr   (ws_waddr),
    .sb_flush   (sb_flush),
    .ds_issue   (ds_issue),
    .ds_stall   (ds_stall),
    .sb_busy    (sb_busy),
    .stall_cnt  (stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives every DUT input for the coming cycle, then lets the
  // combinational outputs settle.
  task automatic applyStimulus(
    input logic       valid,
    input logic       re1,
    input logic [4:0] ra1,
    input logic       re2,
    input logic [4:0] ra2,
    input logic       we,
    input logic [4:0] wa,
    input logic       kill,
    input logic       allowin,
    input logic       wsValid,
    input logic       wsWe,
    input logic [4:0] wsWa,
    input logic       flush
  );
    ds_valid   = valid;
    ds_re1     = re1;
    ds_raddr1  = ra1;
    ds_re2     = re2;
    ds_raddr2  = ra2;
    ds_we      = we;
    ds_waddr   = wa;
    ds_kill    = kill;
    es_allowin = allowin;
    ws_valid   = wsValid;
    ws_we      = wsWe;
    ws_waddr   = wsWa;
    sb_flush   = flush;
    #1;
  endtask

  // Sets every input inactive.
  task automatic idle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  // Advances one clock edge and samples a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    errors   = 0;
    checks   = 0;
    expStall = 32'd0;

    // Reset: everything idle and cleared.
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    idle();
    checkOutput("reset_busy", sb_busy, 32'd0);
    checkOutput("reset_stallcnt", stall_cnt, 32'd0);
    checkOutput("reset_issue", {31'd0, ds_issue}, 32'd0);
    checkOutput("reset_stall", {31'd0, ds_stall}, 32'd0);

    // Issue a write to r5. r5 becomes busy on the following cycle.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 1, 0, 0, 5'd0, 0);
    checkOutput("r5_issue", {31'd0, ds_issue}, 32'd1);
    checkOutput("r5_nostall", {31'd0, ds_stall}, 32'd0);
    tick();
    idle();
    checkOutput("r5_busy", sb_busy, 32'h0000_0020);

    // A reader of r5 stalls, and the stall counter advances each cycle.
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
    checkOutput("raw_stall", {31'd0, ds_stall}, 32'd1);
    checkOutput("raw_noissue", {31'd0, ds_issue}, 32'd0);
    tick();
    expStall = 32'd1;
    checkOutput("raw_stallcnt1", stall_cnt, expStall);
    tick();
    expStall = 32'd2;
    checkOutput("raw_stallcnt2", stall_cnt, expStall);

    // WB retires r5 while the reader waits.
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd5, 0);
`ifdef SB_WB_BYPASS_EN
    checkOutput("retire_issue_bypass", {31'd0, ds_issue}, 32'd1);
`else
    checkOutput("retire_issue_nobypass", {31'd0, ds_issue}, 32'd0);
    expStall = expStall + 32'd1;
`endif
    tick();
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
    checkOutput("after_retire_issue", {31'd0, ds_issue}, 32'd1);
    checkOutput("after_retire_busy", sb_busy, 32'd0);
    checkOutput("after_retire_stallcnt", stall_cnt, expStall);
    tick();

    // r0: writes are not tracked, reads never stall, and a WB write to r0
    // is ignored.
    applyStimulus(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 1, 1, 1, 5'd0, 0);
    checkOutput("r0_issue", {31'd0, ds_issue}, 32'd1);
    checkOutput("r0_nostall", {31'd0, ds_stall}, 32'd0);
    tick();
    idle();
    checkOutput("r0_busy", sb_busy, 32'd0);

    // Three writes to r7 saturate its 2-bit counter.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 1, 0, 0, 5'd0, 0);
      checkOutput("r7_fill_issue", {31'd0, ds_issue}, 32'd1);
      tick();
    end

    // A fourth write to r7 must wait.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 1, 0, 0, 5'd0, 0);
    checkOutput("r7_sat_stall", {31'd0, ds_stall}, 32'd1);
    checkOutput("r7_sat_busy", sb_busy, 32'h0000_0080);
    tick();
    expStall = expStall + 32'd1;
    checkOutput("r7_sat_stallcnt", stall_cnt, expStall);

    // A retire of r7 frees a slot, so the fourth write issues in the same
    // cycle and the count stays at 3.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 1, 1, 1, 5'd7, 0);
    checkOutput("r7_sat_retire_issue", {31'd0, ds_issue}, 32'd1);
    tick();

    // Drain r7 to confirm the count is 3: still busy after two retires,
    // clear after the third.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 5'd7, 0);
    tick();
    tick();
    idle();
    checkOutput("r7_drain2_busy", sb_busy, 32'h0000_0080);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 5'd7, 0);
    tick();
    idle();
    checkOutput("r7_drain3_busy", sb_busy, 32'd0);

    // Make r3 and r9 pending.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 1, 0, 0, 5'd0, 0);
    tick();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 1, 0, 0, 5'd0, 0);
    tick();
    idle();
    checkOutput("flush_pre_busy", sb_busy, 32'h0000_0208);

    // Flush. The simultaneous issue to r11 and retire of r3 are both
    // ignored.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd11, 0, 1, 1, 1, 5'd3, 1);
    checkOutput("flush_issue_prestate", {31'd0, ds_issue}, 32'd1);
    tick();
    idle();
    checkOutput("flush_busy", sb_busy, 32'd0);
    checkOutput("flush_stallcnt", stall_cnt, expStall);

    // A killed instruction neither issues nor stalls, and is not tracked.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 1, 1, 0, 0, 5'd0, 0);
    checkOutput("kill_issue", {31'd0, ds_issue}, 32'd0);
    checkOutput("kill_stall", {31'd0, ds_stall}, 32'd0);
    tick();
    idle();
    checkOutput("kill_busy", sb_busy, 32'd0);

    // EX back-pressure stalls ID, but it is not a hazard stall.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 0, 0, 0, 0, 5'd0, 0);
    checkOutput("allowin0_stall", {31'd0, ds_stall}, 32'd1);
    checkOutput("allowin0_issue", {31'd0, ds_issue}, 32'd0);
    tick();
    idle();
    checkOutput("allowin0_stallcnt", stall_cnt, expStall);
    checkOutput("allowin0_busy", sb_busy, 32'd0);

    // Source-2 hazard on r12.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd12, 0, 1, 0, 0, 5'd0, 0);
    tick();
    applyStimulus(1, 0, 5'd0, 1, 5'd12, 0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
    checkOutput("src2_stall", {31'd0, ds_stall}, 32'd1);
    tick();
    expStall = expStall + 32'd1;
    checkOutput("src2_stallcnt", stall_cnt, expStall);

    // Reset in the middle of activity clears everything, whatever the
    // other inputs are doing.
    reset = 1'b1;
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd8, 0, 1, 1, 1, 5'd12, 0);
    tick();
    reset = 1'b0;
    idle();
    checkOutput("midreset_busy", sb_busy, 32'd0);
    checkOutput("midreset_stallcnt", stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
